// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, majority-vote bit sampling on the
// oversampling tick, and a one-entry holding register with valid/ready handoff.
module uart_rx #(
  parameter int   DATA_BITS    = 8,
  parameter logic PARITY_EN    = 1'b1,
  parameter logic PARITY_TYPE  = 1'b0,
  parameter int   STOP_BITS    = 1,
  parameter int   OVERSAMPLING = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy,
  output logic                 rts
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] CNT_LO   = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLING / 2);
  localparam logic [CW-1:0] CNT_HI   = CW'(OVERSAMPLING / 2 + 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic                 ferr_pend_q;
  logic                 rx_meta_q, rx_s_q;
  logic                 s_lo_q, s_mid_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, perr_q, ferr_q, overrun_q, busy_q, rts_q;

  logic vote, decide, last_stop, ferr_d, perr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // The third vote comes straight from rx_s on the decision tick itself.
  always_comb begin
    vote      = (s_lo_q & s_mid_q) | (s_lo_q & rx_s_q) | (s_mid_q & rx_s_q);
    decide    = tick_16x && (cnt_q == CNT_HI);
    last_stop = decide && (state_q == S_STOP) && (stop_idx_q == STOP_LAST);
    ferr_d    = ferr_pend_q | ~vote;
    perr_d    = PARITY_EN & ((^shift_q) ^ PARITY_TYPE ^ par_q);
  end

  always_ff @(posedge clk) begin
    if (tick_16x) begin
      if (cnt_q == CNT_LO)  s_lo_q  <= rx_s_q;
      if (cnt_q == CNT_MID) s_mid_q <= rx_s_q;
    end
    if (decide && state_q == S_DATA)   shift_q <= {vote, shift_q[DATA_BITS-1:1]};
    if (decide && state_q == S_PARITY) par_q   <= vote;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      ferr_pend_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      rts_q       <= 1'b1;
    end else begin
      overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
        rts_q      <= 1'b1;
      end
      // A consume in the same cycle frees the slot, so the new word still lands.
      if (last_stop) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          perr_q     <= perr_d;
          ferr_q     <= ferr_d;
          rx_valid_q <= 1'b1;
          rts_q      <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end
      if (tick_16x) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q     <= S_START;
              cnt_q       <= '0;
              busy_q      <= 1'b1;
              ferr_pend_q <= 1'b0;
            end
          end
          S_START: begin
            cnt_q <= cnt_q + 1'b1;
            if (decide && vote) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else if (cnt_q == CNT_LAST) begin
              state_q   <= S_DATA;
              cnt_q     <= '0;
              bit_idx_q <= '0;
            end
          end
          S_DATA: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (bit_idx_q == BIT_LAST) begin
                state_q    <= PARITY_EN ? S_PARITY : S_STOP;
                stop_idx_q <= 1'b0;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
          end
          S_PARITY: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q    <= S_STOP;
              cnt_q      <= '0;
              stop_idx_q <= 1'b0;
            end
          end
          S_STOP: begin
            cnt_q <= cnt_q + 1'b1;
            if (last_stop) begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              if (decide) ferr_pend_q <= ferr_d;
              if (cnt_q == CNT_LAST) begin
                cnt_q      <= '0;
                stop_idx_q <= stop_idx_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign rx_busy    = busy_q;
  assign rts        = rts_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (8E1, 16x oversampling, tick every other clk);
// a scoreboard queue holds the words expected at each valid/ready handshake.
module tb_uart_rx;

  localparam int BITCLK       = 32;
  localparam int DECIDE_TICKS = 16 * 10 + 16 / 2 + 2;

  logic       clk = 1'b0;
  logic       tick_16x = 1'b0;
  logic       rst, rx_in, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun, rx_busy, rts;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ovr_cnt = 0;
  int   vfall_cnt = 0;
  logic prev_valid = 1'b0;

  uart_rx #(
    .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_TYPE(1'b0),
    .STOP_BITS(1), .OVERSAMPLING(16)
  ) dut (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .rx_in(rx_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .rx_busy(rx_busy), .rts(rts)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick_16x = ~tick_16x;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: sampled after the bench has driven this cycle's inputs.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #3;
    if (rx_valid && rx_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("word_data", 32'(rx_data), 32'(e.d));
        chk("word_parity_err", 32'(parity_err), 32'(e.pe));
        chk("word_frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
    if (overrun) ovr_cnt++;
    if (prev_valid && !rx_valid) vfall_cnt++;
    prev_valid = rx_valid;
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BITCLK) @(negedge clk);
  endtask

  task automatic idle(input int nbits);
    rx_in = 1'b1;
    repeat (nbits * BITCLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip,
                            input logic stop_v, input bit push);
    exp_t e;
    if (push) begin
      e.d  = d;
      e.pe = pflip;
      e.fe = ~stop_v;
      sb.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ pflip);
    drive_bit(stop_v);
    rx_in = 1'b1;
  endtask

  // Raise rx_ready only during the final stop-bit decision tick of the next frame.
  task automatic ready_pulse();
    logic prev;
    bit   found;
    int   n;
    prev  = rx_busy;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (rx_busy && !prev) found = 1'b1;
      prev = rx_busy;
    end
    if (!found) begin
      chk("b2b_busy_rise_timeout", 32'(found), 32'd1);
    end else begin
      n = 0;
      while (n < DECIDE_TICKS) begin
        @(negedge clk);
        #1;
        if (tick_16x) n++;
      end
      rx_ready = 1'b1;
      @(negedge clk);
      #1;
      rx_ready = 1'b0;
    end
  endtask

  initial begin
    int  v0, o0;
    bit  saw;
    rst = 1'b1;
    rx_in = 1'b1;
    rx_ready = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_rx_busy", 32'(rx_busy), 32'h0);
    chk("rst_rts", 32'(rts), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Clean 0x55 with the consumer always ready.
    v0 = vfall_cnt;
    rx_ready = 1'b1;
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("t1_drained", 32'(sb.size()), 32'd0);
    chk("t1_valid_pulses", 32'(vfall_cnt - v0), 32'd1);
    chk("t1_rx_valid", 32'(rx_valid), 32'h0);
    chk("t1_rts", 32'(rts), 32'h1);

    // Bad parity, then bad stop bit.
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
    idle(2);
    send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t2_drained", 32'(sb.size()), 32'd0);
    chk("t2_rx_busy", 32'(rx_busy), 32'h0);

    // Short glitch: 4 ticks low.
    o0  = ovr_cnt;
    saw = 1'b0;
    rx_in = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 8) rx_in = 1'b1;
      if (rx_busy) saw = 1'b1;
    end
    chk("t3_busy_pulsed", 32'(saw), 32'h1);
    chk("t3_busy_back_low", 32'(rx_busy), 32'h0);
    chk("t3_no_valid", 32'(rx_valid), 32'h0);
    chk("t3_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Overrun: second frame dropped while the first is unread.
    @(negedge clk);
    rx_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    idle(1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("t4_held_data", 32'(rx_data), 32'h11);
    chk("t4_held_valid", 32'(rx_valid), 32'h1);
    chk("t4_rts_low", 32'(rts), 32'h0);
    chk("t4_overrun_once", 32'(ovr_cnt - o0), 32'd1);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_drained", 32'(sb.size()), 32'd0);
    chk("t4_valid_cleared", 32'(rx_valid), 32'h0);
    chk("t4_rts_high", 32'(rts), 32'h1);
    chk("t4_overrun_total", 32'(ovr_cnt - o0), 32'd1);

    // Back-to-back frames, consumed in the same cycle as the next delivery.
    rx_ready = 1'b0;
    idle(1);
    v0 = vfall_cnt;
    o0 = ovr_cnt;
    fork
      begin
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1, 1'b1);
        send_frame(8'h03, 1'b0, 1'b1, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) ready_pulse();
      end
    join
    idle(1);
    chk("t5_valid_never_dropped", 32'(vfall_cnt - v0), 32'd0);
    chk("t5_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    chk("t5_last_data", 32'(rx_data), 32'h03);
    chk("t5_pending", 32'(sb.size()), 32'd1);
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_drained", 32'(sb.size()), 32'd0);
    chk("t5_valid_dropped_once", 32'(vfall_cnt - v0), 32'd1);

    // Reset mid-frame discards both the frame and the held word.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("t6_held_before_rst", 32'(rx_data), 32'h3C);
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
      begin
        repeat (5 * BITCLK + BITCLK / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t6_rst_rx_data", 32'(rx_data), 32'h0);
        chk("t6_rst_rx_valid", 32'(rx_valid), 32'h0);
        chk("t6_rst_rx_busy", 32'(rx_busy), 32'h0);
        chk("t6_rst_rts", 32'(rts), 32'h1);
        chk("t6_rst_flags", 32'({parity_err, frame_err, overrun}), 32'h0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    rx_ready = 1'b1;
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("t6_after_rst_drained", 32'(sb.size()), 32'd0);
    chk("t6_after_rst_valid", 32'(rx_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
